// File: rtl/gpio_port_if.sv
// CPU-side register bus for gpio_port: address, write strobe, write data and
// combinational read data.
interface gpio_port_if;
  logic [31:0] enable_addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output enable_addr,
    output we,
    output data_in,
    input  data_out
  );

  modport slave (
    input  enable_addr,
    input  we,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/gpio_port.sv
// Memory-mapped GPIO bank: direction control, atomic set/clear/toggle on the output
// register, two-flop input synchroniser and W1C edge-interrupt capture.
module gpio_port #(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_FF00,
  parameter int unsigned WIDTH        = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam logic [31:0] AddrIn     = BASE_ADDRESS + 32'h00;
  localparam logic [31:0] AddrOut    = BASE_ADDRESS + 32'h04;
  localparam logic [31:0] AddrSet    = BASE_ADDRESS + 32'h08;
  localparam logic [31:0] AddrClr    = BASE_ADDRESS + 32'h0C;
  localparam logic [31:0] AddrTgl    = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] AddrDir    = BASE_ADDRESS + 32'h14;
  localparam logic [31:0] AddrRiseEn = BASE_ADDRESS + 32'h18;
  localparam logic [31:0] AddrFallEn = BASE_ADDRESS + 32'h1C;
  localparam logic [31:0] AddrIrq    = BASE_ADDRESS + 32'h20;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("gpio_port: WIDTH must be in 1..32");
  end
  if (BASE_ADDRESS[1:0] != 2'b00) begin : g_bad_base
    $error("gpio_port: BASE_ADDRESS must be 4-byte aligned");
  end

  // Upper write-data bits have no storage when WIDTH < 32.
  if (WIDTH < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^bus.data_in[31:WIDTH];
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rdata;
  logic [31:0]      rdata_ext;

  logic sel_in, sel_out, sel_set, sel_clr, sel_tgl;
  logic sel_dir, sel_rise, sel_fall, sel_irq;
  logic wr_out, wr_set, wr_clr, wr_tgl;
  logic wr_dir, wr_rise, wr_fall, wr_irq;

  assign wdata = bus.data_in[WIDTH-1:0];

  // Full 32-bit compare: unaligned or out-of-window addresses never hit.
  assign sel_in   = (bus.enable_addr == AddrIn);
  assign sel_out  = (bus.enable_addr == AddrOut);
  assign sel_set  = (bus.enable_addr == AddrSet);
  assign sel_clr  = (bus.enable_addr == AddrClr);
  assign sel_tgl  = (bus.enable_addr == AddrTgl);
  assign sel_dir  = (bus.enable_addr == AddrDir);
  assign sel_rise = (bus.enable_addr == AddrRiseEn);
  assign sel_fall = (bus.enable_addr == AddrFallEn);
  assign sel_irq  = (bus.enable_addr == AddrIrq);

  assign wr_out  = bus.we & sel_out;
  assign wr_set  = bus.we & sel_set;
  assign wr_clr  = bus.we & sel_clr;
  assign wr_tgl  = bus.we & sel_tgl;
  assign wr_dir  = bus.we & sel_dir;
  assign wr_rise = bus.we & sel_rise;
  assign wr_fall = bus.we & sel_fall;
  assign wr_irq  = bus.we & sel_irq;

  // Enables are the registered (pre-write) values, so a same-edge enable write
  // does not affect the event seen on that edge.
  assign edge_event = (s2_q & ~s3_q & rise_en_q) | (~s2_q & s3_q & fall_en_q);
  assign w1c_mask   = wr_irq ? wdata : '0;

  always_comb begin
    out_d = out_q;
    if (wr_out) begin
      out_d = wdata;
    end else if (wr_set) begin
      out_d = out_q | wdata;
    end else if (wr_clr) begin
      out_d = out_q & ~wdata;
    end else if (wr_tgl) begin
      out_d = out_q ^ wdata;
    end
  end

  always_comb begin
    dir_d     = wr_dir  ? wdata : dir_q;
    rise_en_d = wr_rise ? wdata : rise_en_q;
    fall_en_d = wr_fall ? wdata : fall_en_q;
    // A new event on the same edge as its W1C keeps the bit set.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | edge_event;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q      <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
      s1_q       <= pin_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_in) begin
      rdata = s2_q;
    end else if (sel_out) begin
      rdata = out_q;
    end else if (sel_dir) begin
      rdata = dir_q;
    end else if (sel_rise) begin
      rdata = rise_en_q;
    end else if (sel_fall) begin
      rdata = fall_en_q;
    end else if (sel_irq) begin
      rdata = irq_stat_q;
    end
  end

  always_comb begin
    rdata_ext            = '0;
    rdata_ext[WIDTH-1:0] = rdata;
  end

  assign bus.data_out = rdata_ext;
  assign pin_out      = out_q;
  assign pin_oe       = dir_q;
  assign irq          = |irq_stat_q;

endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped, parametrised general-purpose I/O port combining input and output drivers into one block. Presents a bank of `WIDTH` bidirectional pins behind a small register file decoded from the 32-bit address bus. Adds per-pin direction control, atomic set/clear/toggle writes, a two-flop input synchroniser and edge-triggered interrupt capture. Sits on the CPU data bus alongside the memory and other peripherals; its `data_out` is OR-ed into the CPU read-data mux.

## Interface

Parameters:
- `BASE_ADDRESS`, default 32'hFFFF_FF00: byte address of register offset 0x00. Must be 4-byte aligned.
- `WIDTH`, default 8: number of pins; legal range 1..32.

Ports:
- `CLK` input 1: single clock; everything is on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `enable_addr` input 32: bus address.
- `we` input 1: write strobe; qualified by an address match.
- `data_in` input 32: write data; bits [31:WIDTH] ignored.
- `data_out` output 32: read data; combinational; 0 when no register matches.
- `pin_in` input WIDTH: asynchronous pad inputs.
- `pin_out` output WIDTH: output data register value.
- `pin_oe` output WIDTH: output enable (= DIR); 1 = drive.
- `irq` output 1: OR of all IRQ_STAT bits.

## Operation

- Register map (offset from `BASE_ADDRESS`):
  - 0x00 IN, RO: synchronised pins.
  - 0x04 OUT, RW.
  - 0x08 SET, WO: OUT |= wdata.
  - 0x0C CLR, WO: OUT &= ~wdata.
  - 0x10 TGL, WO: OUT ^= wdata.
  - 0x14 DIR, RW.
  - 0x18 RISE_EN, RW.
  - 0x1C FALL_EN, RW.
  - 0x20 IRQ_STAT, R/W1C.
- Address match: `enable_addr == BASE_ADDRESS + offset`, full 32-bit compare. Unmapped or unaligned addresses do not match: no write, read 0.
- Reads: `data_out = {(32-WIDTH) zeros, reg}`. WO registers read 0.
- Writes: occur on the rising `CLK` edge when `we`=1 and the address matches. Writes to IN are ignored.
- Synchroniser chain `s1 -> s2 -> s3`, all WIDTH wide:
  - `s1` samples `pin_in`.
  - IN reads `s2`.
  - `s3` is the previous `s2`.
- Edge detect, per bit: `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- Status update: `IRQ_STAT[i]` sets on an edge when `(rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])`.
- Sampling is independent of DIR, so an output pin looped back at the pad also raises events.
- `irq = |IRQ_STAT`, driven directly from flops.

## Timing

- Reset (`RST_N`=0, asynchronous): OUT, DIR, RISE_EN, FALL_EN, IRQ_STAT, s1, s2 and s3 all clear to 0.
  - Resulting outputs: `pin_out`=0, `pin_oe`=0, `irq`=0. `data_out` shows 0 for every register.
  - Reset release is synchronous to the design only through the flops; there is no extra deassertion logic.
- After reset, a pin held high produces a rise in s2/s3. It is not captured because RISE_EN=0.
- Write latency: the new OUT/DIR value appears on `pin_out`/`pin_oe` right after the write edge (1 cycle).
- Input latency, for a pin change settled before edge k:
  - s1 updates at edge k.
  - IN reflects the change after edge k+1.
  - IRQ_STAT and `irq` assert after edge k+2.
- Glitches shorter than one clock period may be missed; this is not required behaviour either way.
- IRQ_STAT W1C on the same edge as a new event on the same bit: the set wins and the bit stays 1. Other written bits clear.
- Only one register is written per cycle, so SET/CLR/TGL cannot collide.
- RISE_EN/FALL_EN written on the same edge as an edge condition: the old enable value is used.
- Reset asserted mid-operation: state clears immediately, without waiting for `CLK`. A pending `irq` drops combinationally with the flops.

## Test plan

- Reset, then read each offset 0x00–0x20 with `pin_in`=0 -> all read 0; `pin_out`=0, `pin_oe`=0, `irq`=0. Read `BASE_ADDRESS`+0x24 -> 0.
- WIDTH=8: write OUT=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> `pin_out` goes 0xA5, 0xAF, 0x2E, 0xD1 on successive edges. OUT reads 0x000000D1; SET reads 0.
- Write DIR=0x3C with data bits [31:8]=0xFFFFFF -> `pin_oe`=0x3C, DIR reads 0x0000003C.
- Drive `pin_in` 0x00 -> 0x81 before edge k -> IN reads 0x00 after k and 0x81 after k+1.
- RISE_EN=0x01, FALL_EN=0x80:
  - `pin_in` 0x00 -> 0x81 -> IRQ_STAT=0x01 and `irq`=1 after k+2.
  - Then `pin_in` -> 0x01 -> IRQ_STAT=0x81.
  - W1C 0x01 -> IRQ_STAT reads 0x80.
  - W1C 0x80 on the same edge as a new bit-7 fall -> bit 7 stays 1.
- With OUT=0xFF, IRQ_STAT=0x01 and `irq`=1, pulse `RST_N` low between clock edges -> `pin_out`, `irq` and all registers go to 0 before the next `CLK` edge.
